// File: rtl/board_input_conditioner.sv
// ----------------------------------------------------------------------------
// board_input_conditioner
//
// Front end for raw board push-buttons. Each channel is synchronised,
// debounced and edge-detected. One channel (RST_CH) also acts as a long-press
// reset source that produces a timed, registered, synchronous system reset.
// A power-on reset pulse of the same length follows every rst_n release.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous button levels, active-high (N bits)
//   btn_level  debounced level per channel
//   btn_rise   one-cycle pulse on an accepted 0->1 transition
//   btn_fall   one-cycle pulse on an accepted 1->0 transition
//   sys_rst    registered active-high reset for downstream logic
// ----------------------------------------------------------------------------
module board_input_conditioner #(
   parameter int N               = 3,
   parameter int DEBOUNCE_CYCLES = 750000,
   parameter int HOLD_CYCLES     = 75000000,
   parameter int RST_PULSE       = 16,
   parameter int RST_CH          = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] btn_rise,
   output logic [N-1:0] btn_fall,
   output logic         sys_rst
);

   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam int PULSE_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

   localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE - 1);

   typedef enum logic [1:0] {
      StPor,
      StIdle,
      StAssert,
      StWaitRel
   } state_e;

   logic [N-1:0]       sync1;
   logic [N-1:0]       sync2;
   logic [CNT_W-1:0]   db_cnt [N];
   logic [HOLD_W-1:0]  hold_cnt;
   logic [PULSE_W-1:0] pulse_cnt;
   state_e             state;
   logic               rst_lvl;

   assign rst_lvl = btn_level[RST_CH];

   // Two-flop synchroniser; only sync2 is used downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
   // differing samples; any agreeing sample restarts the count. The edge
   // pulse is registered on the same edge as the level so they coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            db_cnt[i] <= '0;
         end
         btn_level <= '0;
         btn_rise  <= '0;
         btn_fall  <= '0;
      end else begin
         btn_rise <= '0;
         btn_fall <= '0;
         for (int i = 0; i < N; i++) begin
            if (sync2[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]    <= '0;
               btn_level[i] <= sync2[i];
               btn_rise[i]  <= sync2[i];
               btn_fall[i]  <= ~sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Hold counter only runs in IDLE, so a press that continues through
   // ASSERT/WAIT_REL can never accumulate toward a second trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (rst_lvl && (state == StIdle)) begin
         if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end else begin
         hold_cnt <= '0;
      end
   end

   // Reset sequencer. sys_rst is a flop so it is glitch-free and deasserts
   // synchronously. POR and ASSERT share pulse_cnt: sys_rst is already high
   // when either state is entered, so exiting at RST_PULSE-1 gives exactly
   // RST_PULSE cycles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StPor;
         pulse_cnt <= '0;
         sys_rst   <= 1'b1;
      end else begin
         case (state)
            StPor, StAssert: begin
               if (pulse_cnt == PULSE_LAST) begin
                  pulse_cnt <= '0;
                  sys_rst   <= 1'b0;
                  state     <= (state == StPor) ? StIdle : StWaitRel;
               end else begin
                  pulse_cnt <= pulse_cnt + PULSE_W'(1);
               end
            end
            StIdle: begin
               if (hold_cnt == HOLD_MAX) begin
                  pulse_cnt <= '0;
                  sys_rst   <= 1'b1;
                  state     <= StAssert;
               end
            end
            StWaitRel: begin
               if (!rst_lvl) begin
                  state <= StIdle;
               end
            end
            default: begin
               pulse_cnt <= '0;
               sys_rst   <= 1'b1;
               state     <= StPor;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_input_conditioner.sv
// ----------------------------------------------------------------------------
// tb_board_input_conditioner
//
// Bench for board_input_conditioner with N=3, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8, RST_PULSE=3, RST_CH=0. Inputs are driven 1 time unit after
// a rising edge; outputs are sampled 1 time unit after the next rising edge.
// Edge j in each scenario is the j-th edge after the stimulus starts, so a
// press starting at edge s is accepted on edge s+D+1.
// Observation vector: {btn_level, btn_rise, btn_fall, sys_rst}.
// ----------------------------------------------------------------------------
module tb_board_input_conditioner;

   localparam int N  = 3;
   localparam int D  = 4;
   localparam int H  = 8;
   localparam int P  = 3;
   localparam int RC = 0;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_rise;
   logic [N-1:0] btn_fall;
   logic         sys_rst;

   logic [3*N:0] got;
   logic [3*N:0] exp_q[$];
   int           n_tests = 0;
   int           n_fails = 0;

   assign got = {btn_level, btn_rise, btn_fall, sys_rst};

   always #5 clk = ~clk;

   board_input_conditioner #(
      .N               (N),
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .RST_PULSE       (P),
      .RST_CH          (RC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .sys_rst   (sys_rst)
   );

   function automatic logic [3*N:0] pack(input logic [N-1:0] l, input logic [N-1:0] r,
                                         input logic [N-1:0] f, input logic s);
      return {l, r, f, s};
   endfunction

   // Asynchronous reset, then the power-on pulse after release.
   task automatic test_reset();
      logic [3*N:0] e;
      rst_n  = 1'b0;
      btn_in = '0;
      #1;
      e = pack('0, '0, '0, 1'b1);
      n_tests++;
      if (got !== e) begin
         n_fails++;
         $display("FAIL reset_async got=%b exp=%b", got, e);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i <= P + 4; i++) begin
         if (i > 0) @(posedge clk);
         exp_q.push_back(pack('0, '0, '0, i < P));
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL reset_por i=%0d got=%b exp=%b", i, got, e);
         end
      end
   endtask

   // Channel 1 press held: accepted on edge D+2 with a single rise pulse.
   task automatic test_debounce_rise();
      logic [3*N:0] e;
      for (int j = 1; j <= D + 6; j++) begin
         btn_in = 3'b010;
         exp_q.push_back(pack((j >= D + 2) ? 3'b010 : 3'b000,
                              (j == D + 2) ? 3'b010 : 3'b000, '0, 1'b0));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL debounce_rise j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   // Channel 2: short pulse rejected; glitch inside a long press restarts the count.
   task automatic test_glitch();
      logic [3*N:0] e;
      int           rise_e;
      int           fall_e;
      logic         b2;
      logic         l2;
      for (int j = 1; j <= 12; j++) begin
         b2     = (j <= D - 1);
         btn_in = {b2, 1'b1, 1'b0};
         exp_q.push_back(pack(3'b010, '0, '0, 1'b0));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL glitch_short j=%0d got=%b exp=%b", j, got, e);
         end
      end
      // High on edges 1..10 except edge 3; first clean high sample is edge 4.
      rise_e = 4 + D + 1;
      fall_e = 11 + D + 1;
      for (int j = 1; j <= 18; j++) begin
         b2     = (j <= 10) && (j != 3);
         l2     = (j >= rise_e) && (j < fall_e);
         btn_in = {b2, 1'b1, 1'b0};
         exp_q.push_back(pack({l2, 2'b10}, {(j == rise_e), 2'b00},
                              {(j == fall_e), 2'b00}, 1'b0));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL glitch_long j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   // Long press triggers one reset pulse, continued hold does not retrigger,
   // release then a new full hold retriggers.
   task automatic test_long_press();
      logic [3*N:0] e;
      int           ra, fa, rb, fb, ta, tb;
      logic         b0, l0, s;
      ra = 1 + D + 1;
      fa = 69 + D + 1;
      rb = 77 + D + 1;
      fb = 97 + D + 1;
      ta = ra + H + 1;
      tb = rb + H + 1;
      for (int j = 1; j <= 104; j++) begin
         b0     = (j <= 68) || ((j >= 77) && (j <= 96));
         l0     = ((j >= ra) && (j < fa)) || ((j >= rb) && (j < fb));
         s      = ((j >= ta) && (j < ta + P)) || ((j >= tb) && (j < tb + P));
         btn_in = {1'b0, 1'b1, b0};
         exp_q.push_back(pack({2'b01, l0}, {2'b00, (j == ra) || (j == rb)},
                              {2'b00, (j == fa) || (j == fb)}, s));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL long_press j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   // Five debounced-high cycles leave no trace; a later hold needs all H cycles.
   task automatic test_short_press();
      logic [3*N:0] e;
      int           ra, fa, rb, fb, tb;
      logic         b0, l0, s;
      ra = 1 + D + 1;
      fa = 6 + D + 1;
      rb = 20 + D + 1;
      fb = 40 + D + 1;
      tb = rb + H + 1;
      for (int j = 1; j <= 48; j++) begin
         b0     = (j <= 5) || ((j >= 20) && (j <= 39));
         l0     = ((j >= ra) && (j < fa)) || ((j >= rb) && (j < fb));
         s      = (j >= tb) && (j < tb + P);
         btn_in = {1'b0, 1'b1, b0};
         exp_q.push_back(pack({2'b01, l0}, {2'b00, (j == ra) || (j == rb)},
                              {2'b00, (j == fa) || (j == fb)}, s));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL short_press j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   // All channels change on the same edge: pulses coincide, rise and fall mixed.
   task automatic test_simultaneous();
      logic [3*N:0] e;
      int           ra, fa, ta;
      logic [N-1:0] l, r, f;
      ra = 1 + D + 1;
      fa = 20 + D + 1;
      ta = ra + H + 1;
      for (int j = 1; j <= 28; j++) begin
         btn_in = (j <= 19) ? 3'b101 : 3'b000;
         l      = (j < ra) ? 3'b010 : ((j < fa) ? 3'b101 : 3'b000);
         r      = (j == ra) ? 3'b101 : 3'b000;
         f      = (j == ra) ? 3'b010 : ((j == fa) ? 3'b101 : 3'b000);
         exp_q.push_back(pack(l, r, f, (j >= ta) && (j < ta + P)));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL simultaneous j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   // rst_n asserted one cycle into ASSERT: immediate clear, fresh POR, then IDLE.
   task automatic test_reset_in_assert();
      logic [3*N:0] e;
      int           ra, ta;
      ra = 1 + D + 1;
      ta = ra + H + 1;
      for (int j = 1; j <= ta + 1; j++) begin
         btn_in = 3'b001;
         exp_q.push_back(pack((j >= ra) ? 3'b001 : 3'b000, (j == ra) ? 3'b001 : 3'b000,
                              '0, (j >= ta)));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL assert_pre j=%0d got=%b exp=%b", j, got, e);
         end
      end
      // Mid-cycle, away from any clock edge.
      #2;
      rst_n  = 1'b0;
      btn_in = '0;
      #1;
      e = pack('0, '0, '0, 1'b1);
      n_tests++;
      if (got !== e) begin
         n_fails++;
         $display("FAIL assert_async_clear got=%b exp=%b", got, e);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i <= P + 3; i++) begin
         if (i > 0) @(posedge clk);
         exp_q.push_back(pack('0, '0, '0, i < P));
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL assert_por i=%0d got=%b exp=%b", i, got, e);
         end
      end
      // A full hold must trigger again, showing the sequencer is back in IDLE.
      for (int j = 1; j <= ta + P + 2; j++) begin
         btn_in = 3'b001;
         exp_q.push_back(pack((j >= ra) ? 3'b001 : 3'b000, (j == ra) ? 3'b001 : 3'b000,
                              '0, (j >= ta) && (j < ta + P)));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_tests++;
         if (got !== e) begin
            n_fails++;
            $display("FAIL assert_idle j=%0d got=%b exp=%b", j, got, e);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_debounce_rise();
      test_glitch();
      test_long_press();
      test_short_press();
      test_simultaneous();
      test_reset_in_assert();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
